// File: rtl/dht11_top.sv
// dht11_top: DHT11 single-wire sensor controller (start pulse + 40-bit frame decode).
// Optional feature macro: DHT11_CHECKSUM_EN enables checksum verification of each frame.
module dht11_top #(
    parameter int BYTE_SZ  = 8,
    parameter int VALUE_SZ = 2 * BYTE_SZ,
    parameter int CLK_DIV  = 50,
    parameter int START_US = 20000
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       I_EN,
    output logic signed [VALUE_SZ-1:0] O_VALUE,
    output logic                       O_ERR,
    output logic                       O_CONV,
    output logic                       O_BUSY,
    inout  wire                        IO_DHT11
);

    localparam int FRAME_SZ = 5 * BYTE_SZ;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W    = 16;
    localparam int CNT_W    = $clog2(FRAME_SZ + 1);

    localparam logic [TMR_W-1:0] T_START = TMR_W'(START_US);
    localparam logic [TMR_W-1:0] T_RESP  = TMR_W'(200);
    localparam logic [TMR_W-1:0] T_PHASE = TMR_W'(100);
    localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(48);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_RESP, RESP_LOW,
        RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q;
    logic [1:0]             sync_q;
    logic                   dly_q;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_SZ-1:0]    data_q, data_d;
    logic [VALUE_SZ-1:0]    value_q, value_d;
    logic                   err_q, err_d;
    logic                   conv_q, conv_d;
    logic                   busy_q, busy_d;
    logic                   timeout;
    logic                   frame_ok;
    logic                   strobe;
    logic                   rs_dht11_in;
    logic                   fl_dht11_in;
    logic [BYTE_SZ-1:0]     b1, b3;

    assign strobe      = (div_q == DIV_W'(CLK_DIV - 1));
    assign rs_dht11_in = sync_q[1] & ~dly_q;
    assign fl_dht11_in = ~sync_q[1] & dly_q;

    assign b1 = data_q[FRAME_SZ-1 -: BYTE_SZ];
    assign b3 = data_q[3*BYTE_SZ-1 -: BYTE_SZ];

`ifdef DHT11_CHECKSUM_EN
    logic [BYTE_SZ-1:0] b2, b4, b5, sum;
    assign b2       = data_q[4*BYTE_SZ-1 -: BYTE_SZ];
    assign b4       = data_q[2*BYTE_SZ-1 -: BYTE_SZ];
    assign b5       = data_q[BYTE_SZ-1:0];
    assign sum      = b1 + b2 + b3 + b4;
    assign frame_ok = (sum == b5);
`else
    assign frame_ok = 1'b1;
`endif

    // Open drain: only ever pull low, and only while sending the start pulse.
    assign IO_DHT11 = (state_q == START) ? 1'b0 : 1'bz;

    assign O_VALUE = value_q;
    assign O_ERR   = err_q;
    assign O_CONV  = conv_q;
    assign O_BUSY  = busy_q;

    // 1 us tick: counter wraps every CLK_DIV cycles
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)      div_q <= '0;
        else if (strobe) div_q <= '0;
        else             div_q <= div_q + DIV_W'(1);
    end

    // Line synchronizer plus one delay stage for edge detection
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= 2'b11;
            dly_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], IO_DHT11};
            dly_q  <= sync_q[1];
        end
    end

    // FSM, timer, shift register and output registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            value_q <= value_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: each phase waits for one line edge under a us timeout
    always_comb begin
        state_d = state_q;
        timer_d = strobe ? timer_q + TMR_W'(1) : timer_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        value_d = value_q;
        err_d   = err_q;
        conv_d  = 1'b0;
        busy_d  = busy_q;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (I_EN) begin
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (timer_q >= T_START) begin
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (fl_dht11_in) begin
                    timer_d = '0;
                    state_d = RESP_LOW;
                end else begin
                    timeout = (timer_q >= T_RESP);
                end
            end
            RESP_LOW: begin
                if (rs_dht11_in) begin
                    timer_d = '0;
                    state_d = RESP_HIGH;
                end else begin
                    timeout = (timer_q >= T_PHASE);
                end
            end
            RESP_HIGH: begin
                if (fl_dht11_in) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = BIT_LOW;
                end else begin
                    timeout = (timer_q >= T_PHASE);
                end
            end
            BIT_LOW: begin
                if (rs_dht11_in) begin
                    timer_d = '0;
                    state_d = BIT_HIGH;
                end else begin
                    timeout = (timer_q >= T_PHASE);
                end
            end
            BIT_HIGH: begin
                if (fl_dht11_in) begin
                    data_d  = {data_q[FRAME_SZ-2:0], (timer_q > T_ONE)};
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = '0;
                    if (cnt_q == CNT_W'(FRAME_SZ - 1)) state_d = CHECK;
                    else                               state_d = BIT_LOW;
                end else begin
                    timeout = (timer_q >= T_PHASE);
                end
            end
            CHECK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (frame_ok) begin
                    value_d = VALUE_SZ'({b1, b3});
                    conv_d  = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_dht11_top.sv
// tb_dht11_top: directed bench for dht11_top with a behavioural DHT11 sensor.
// Expectations for bad-checksum frames follow DHT11_CHECKSUM_EN.
module tb_dht11_top;

    localparam int DIV      = 2;
    localparam int START_US = 100;

`ifdef DHT11_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sens_low = 1'b0;
    logic [15:0] value;
    logic        err, conv, busy;
    wire         dht;

    int checks = 0;
    int errors = 0;
    int conv_cnt = 0;
    int rs_cnt = 0;
    int fl_cnt = 0;

    assign dht = sens_low ? 1'b0 : 1'bz;
    pullup (dht);

    always #5 clk = ~clk;

    dht11_top #(
        .BYTE_SZ (8),
        .VALUE_SZ(16),
        .CLK_DIV (DIV),
        .START_US(START_US)
    ) dut (
        .CLK     (clk),
        .RST_n   (rst_n),
        .I_EN    (en),
        .O_VALUE (value),
        .O_ERR   (err),
        .O_CONV  (conv),
        .O_BUSY  (busy),
        .IO_DHT11(dht)
    );

    always @(posedge clk) begin
        if (conv)             conv_cnt <= conv_cnt + 1;
        if (dut.rs_dht11_in)  rs_cnt   <= rs_cnt + 1;
        if (dut.fl_dht11_in)  fl_cnt   <= fl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * DIV) @(posedge clk);
        #1;
    endtask

    task automatic wait_line(input logic v, input int max_cyc,
                             input string tag, output int n);
        n = 0;
        while (dht !== v && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, dht, v);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag,
                             output int n);
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Sensor side: answers the start pulse and sends nbits of frame f MSB first.
    // A full frame ends with the line held low (final bit terminator).
    task automatic sensor_reply(input logic [39:0] f, input int nbits,
                                input int en_bit);
        int n;
        wait_line(1'b0, 4, "start_low", n);
        wait_line(1'b1, (START_US + 2) * DIV, "release", n);
        wait_us(20);
        sens_low = 1'b1;
        wait_us(80);
        sens_low = 1'b0;
        wait_us(80);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1;
            if (i == en_bit) begin
                pulse_en();
                chk("busy_ign", busy, 1);
            end
            wait_us(50);
            sens_low = 1'b0;
            wait_us(f[39-i] ? 70 : 28);
        end
        if (nbits == 40) sens_low = 1'b1;
    endtask

    task automatic sensor_end();
        wait_us(50);
        sens_low = 1'b0;
        wait_us(5);
    endtask

    task automatic run_frame(input string tag, input logic [39:0] f,
                             input int en_bit, input logic ok,
                             input logic [15:0] exp_v);
        int n, c0, r0, f0;
        c0 = conv_cnt;
        r0 = rs_cnt;
        f0 = fl_cnt;
        pulse_en();
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_errclr"}, err, 0);
        sensor_reply(f, 40, en_bit);
        wait_idle(20, {tag, "_idle"}, n);
        chk({tag, "_val"}, value, exp_v);
        chk({tag, "_conv"}, conv, ok);
        chk({tag, "_err"}, err, !ok);
        @(posedge clk); #1;
        chk({tag, "_conv1"}, conv, 0);
        sensor_end();
        chk({tag, "_nconv"}, conv_cnt - c0, ok ? 1 : 0);
        chk({tag, "_rs"}, rs_cnt - r0, 43);
        chk({tag, "_fl"}, fl_cnt - f0, 43);
    endtask

    initial begin
        int n, k, last, gap_bad, c0;
        logic [15:0] cur;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", value, 0);
        chk("rst_err", err, 0);
        chk("rst_conv", conv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line", dht, 1);
        chk("rst_strobe", dut.strobe, 0);
        rst_n = 1'b1;

        // idle 1 ms: strobe cadence, no activity
        n = 0;
        last = -1;
        gap_bad = 0;
        for (k = 0; k < 1000 * DIV; k++) begin
            @(posedge clk); #1;
            if (dut.strobe) begin
                n++;
                if (last >= 0 && k - last != DIV) gap_bad++;
                last = k;
            end
        end
        chk("strobe_cnt", n, 1000);
        chk("strobe_gap", gap_bad, 0);
        chk("idle_line", dht, 1);
        chk("idle_busy", busy, 0);
        chk("idle_val", value, 0);
        chk("idle_edges", rs_cnt + fl_cnt, 0);

        // good frame
        run_frame("good", 40'h5500AA00FF, -1, 1'b1, 16'h55AA);
        cur = 16'h55AA;

        // bad checksum, same data
        run_frame("badck", 40'h5500AA00FE, -1, !CK, 16'h55AA);

        // bad checksum, different data
        run_frame("badck2", 40'h12003400FF, -1, !CK,
                  CK ? 16'h55AA : 16'h1234);
        cur = CK ? 16'h55AA : 16'h1234;

        // no sensor response
        c0 = conv_cnt;
        pulse_en();
        chk("to_busy", busy, 1);
        chk("to_errclr", err, 0);
        wait_line(1'b0, 4, "to_low", n);
        wait_line(1'b1, (START_US + 2) * DIV, "to_release", n);
        chk("start_len",
            (n >= (START_US - 1) * DIV) && (n <= START_US * DIV + 2), 1);
        wait_idle(250 * DIV, "to_idle", n);
        chk("to_time", (n >= 199 * DIV) && (n <= 201 * DIV), 1);
        chk("to_err", err, 1);
        chk("to_val", value, cur);
        wait_us(10);
        chk("err_hold", err, 1);
        chk("to_nconv", conv_cnt - c0, 0);

        // second I_EN during transfer is ignored; checksum wraps mod 256
        run_frame("ign", 40'h8090701090, 5, 1'b1, 16'h8070);

        // reset in the middle of the bit stream
        pulse_en();
        sensor_reply(40'h5500AA00FF, 10, -1);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_val", value, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_line", dht, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_us(5);

        // reset while the start pulse is being driven
        pulse_en();
        wait_us(5);
        chk("st_drive", dht, 0);
        rst_n = 1'b0;
        #1;
        chk("st_rst_line", dht, 1);
        chk("st_rst_busy", busy, 0);
        chk("st_rst_conv", conv, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_us(5);
        chk("post_line", dht, 1);
        chk("post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
